// File: rtl/mem_pending_tracker.sv
// Per-channel request/response stage: 2-entry request FIFO toward memory,
// response pass-through, and an outstanding-read counter with sticky underflow flag.
module mem_pending_tracker #(
    parameter int WORD_SIZE   = 4,
    parameter int ADDR_WIDTH  = 30,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 16,
    localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     in_req_valid,
    output logic                     in_req_ready,
    input  logic                     in_req_rw,
    input  logic [WORD_SIZE-1:0]     in_req_byteen,
    input  logic [ADDR_WIDTH-1:0]    in_req_addr,
    input  logic [WORD_SIZE*8-1:0]   in_req_data,
    input  logic [TAG_WIDTH-1:0]     in_req_tag,

    output logic                     out_req_valid,
    input  logic                     out_req_ready,
    output logic                     out_req_rw,
    output logic [WORD_SIZE-1:0]     out_req_byteen,
    output logic [ADDR_WIDTH-1:0]    out_req_addr,
    output logic [WORD_SIZE*8-1:0]   out_req_data,
    output logic [TAG_WIDTH-1:0]     out_req_tag,

    input  logic                     out_rsp_valid,
    input  logic [WORD_SIZE*8-1:0]   out_rsp_data,
    input  logic [TAG_WIDTH-1:0]     out_rsp_tag,
    output logic                     out_rsp_ready,

    output logic                     in_rsp_valid,
    output logic [WORD_SIZE*8-1:0]   in_rsp_data,
    output logic [TAG_WIDTH-1:0]     in_rsp_tag,
    input  logic                     in_rsp_ready,

    input  logic                     drain,
    output logic                     idle,
    output logic [CNT_W-1:0]         pending_count,
    output logic                     underflow_err
);

    typedef struct packed {
        logic                   rw;
        logic [WORD_SIZE-1:0]   byteen;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [WORD_SIZE*8-1:0] data;
        logic [TAG_WIDTH-1:0]   tag;
    } req_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    req_t             buf_q [2];
    req_t             in_entry;
    req_t             head;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       buf_cnt;
    logic [CNT_W-1:0] pending_q;
    logic             err_q;
    logic             push;
    logic             pop;
    logic             read_fire;
    logic             rsp_fire;

    assign in_entry = '{rw: in_req_rw, byteen: in_req_byteen, addr: in_req_addr,
                        data: in_req_data, tag: in_req_tag};

    // Ready is independent of out_req_ready so the upstream path has no
    // combinational dependency on the memory side.
    assign in_req_ready = reset & (buf_cnt != 2'd2) & (pending_q < MAX_CNT) & ~drain;
    assign push         = in_req_valid & in_req_ready;
    assign pop          = out_req_valid & out_req_ready;
    assign read_fire    = push & ~in_req_rw;
    assign rsp_fire     = out_rsp_valid & in_rsp_ready;

    assign head           = buf_q[rd_ptr];
    assign out_req_valid  = (buf_cnt != 2'd0);
    assign out_req_rw     = head.rw;
    assign out_req_byteen = head.byteen;
    assign out_req_addr   = head.addr;
    assign out_req_data   = head.data;
    assign out_req_tag    = head.tag;

    assign in_rsp_valid  = out_rsp_valid;
    assign in_rsp_data   = out_rsp_data;
    assign in_rsp_tag    = out_rsp_tag;
    assign out_rsp_ready = in_rsp_ready;

    assign pending_count = pending_q;
    assign underflow_err = err_q;
    assign idle          = (pending_q == '0) && (buf_cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + 2'(push) - 2'(pop);
        end
    end

    // A response at zero with a coincident read is treated as balanced.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else if (read_fire && !rsp_fire) begin
            pending_q <= pending_q + CNT_W'(1);
        end else if (rsp_fire && !read_fire) begin
            if (pending_q == '0) begin
                err_q <= 1'b1;
            end else begin
                pending_q <= pending_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_pending_tracker.sv
// Directed bench for mem_pending_tracker with MAX_PENDING=4.
module tb_mem_pending_tracker;

    localparam int WS = 4;
    localparam int AW = 30;
    localparam int TW = 8;
    localparam int MP = 4;
    localparam int CW = $clog2(MP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_req_valid, in_req_ready, in_req_rw;
    logic [WS-1:0] in_req_byteen;
    logic [AW-1:0] in_req_addr;
    logic [WS*8-1:0] in_req_data;
    logic [TW-1:0] in_req_tag;
    logic          out_req_valid, out_req_ready, out_req_rw;
    logic [WS-1:0] out_req_byteen;
    logic [AW-1:0] out_req_addr;
    logic [WS*8-1:0] out_req_data;
    logic [TW-1:0] out_req_tag;
    logic          out_rsp_valid, out_rsp_ready;
    logic [WS*8-1:0] out_rsp_data;
    logic [TW-1:0] out_rsp_tag;
    logic          in_rsp_valid, in_rsp_ready;
    logic [WS*8-1:0] in_rsp_data;
    logic [TW-1:0] in_rsp_tag;
    logic          drain, idle, underflow_err;
    logic [CW-1:0] pending_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_pending_tracker #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
        .in_req_byteen(in_req_byteen), .in_req_addr(in_req_addr), .in_req_data(in_req_data),
        .in_req_tag(in_req_tag),
        .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req_rw(out_req_rw),
        .out_req_byteen(out_req_byteen), .out_req_addr(out_req_addr), .out_req_data(out_req_data),
        .out_req_tag(out_req_tag),
        .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
        .out_rsp_ready(out_rsp_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready),
        .drain(drain), .idle(idle), .pending_count(pending_count), .underflow_err(underflow_err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic offer(input logic rw, input logic [TW-1:0] tag);
        in_req_valid  = 1'b1;
        in_req_rw     = rw;
        in_req_tag    = tag;
        in_req_addr   = AW'(32'h100 + 32'(tag));
        in_req_data   = 32'hA5000000 | 32'(tag);
        in_req_byteen = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; in_req_valid = 1'b0; in_req_rw = 1'b0; in_req_byteen = '0;
        in_req_addr = '0; in_req_data = '0; in_req_tag = '0; out_req_ready = 1'b1;
        out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0; in_rsp_ready = 1'b1;
        drain = 1'b0;
        tick(); tick();
        offer(1'b0, 8'd0);
        #1;
        chk("rst_ready", in_req_ready, 0);
        chk("rst_out_valid", out_req_valid, 0);
        chk("rst_pending", pending_count, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", underflow_err, 0);

        // back-to-back reads, tags 0..3
        reset = 1'b1;
        #1 chk("first_ready", in_req_ready, 1);
        tick(); offer(1'b0, 8'd1);
        #1 chk("b2b_tag0", out_req_tag, 0); chk("b2b_p1", pending_count, 1);
        tick(); offer(1'b0, 8'd2);
        #1 chk("b2b_tag1", out_req_tag, 1); chk("b2b_p2", pending_count, 2);
        tick(); offer(1'b0, 8'd3);
        #1 chk("b2b_tag2", out_req_tag, 2); chk("b2b_p3", pending_count, 3);
        tick(); in_req_valid = 1'b0;
        #1 chk("b2b_tag3", out_req_tag, 3); chk("b2b_p4", pending_count, 4);
        chk("b2b_idle", idle, 0); chk("b2b_full_ready", in_req_ready, 0);
        chk("b2b_addr3", out_req_addr, 32'h103);
        tick();
        #1 chk("b2b_empty", out_req_valid, 0);

        // response pass-through and release from the max
        out_rsp_valid = 1'b1; out_rsp_data = 32'hDEAD0001; out_rsp_tag = 8'h05;
        #1 chk("rsp_valid", in_rsp_valid, 1); chk("rsp_data", in_rsp_data, 32'hDEAD0001);
        chk("rsp_tag", in_rsp_tag, 8'h05); chk("rsp_ready", out_rsp_ready, 1);
        chk("rsp_max_ready", in_req_ready, 0);
        tick(); out_rsp_valid = 1'b0;
        #1 chk("rsp_p3", pending_count, 3); chk("rsp_ready_rise", in_req_ready, 1);
        out_rsp_valid = 1'b1;
        repeat (3) tick();
        out_rsp_valid = 1'b0;
        #1 chk("rsp_p0", pending_count, 0); chk("rsp_idle", idle, 1);

        // upstream not ready: no response fire
        out_rsp_valid = 1'b1; in_rsp_ready = 1'b0;
        #1 chk("bp_rsp_ready", out_rsp_ready, 0);
        tick(); out_rsp_valid = 1'b0; in_rsp_ready = 1'b1;
        #1 chk("bp_no_err", underflow_err, 0);

        // limit at MAX_PENDING=4
        offer(1'b0, 8'd10); tick();
        offer(1'b0, 8'd11); tick();
        offer(1'b0, 8'd12); tick();
        offer(1'b0, 8'd13);
        #1 chk("max_tag12", out_req_tag, 12);
        tick(); offer(1'b0, 8'd14);
        #1 chk("max_ready0", in_req_ready, 0); chk("max_p4", pending_count, 4);
        chk("max_tag13", out_req_tag, 13);
        tick(); tick();
        #1 chk("max_hold_p4", pending_count, 4); chk("max_hold_ready", in_req_ready, 0);
        out_rsp_valid = 1'b1;
        #1 chk("max_same_cycle", in_req_ready, 0);
        tick(); out_rsp_valid = 1'b0;
        #1 chk("max_release", in_req_ready, 1); chk("max_p3", pending_count, 3);
        tick(); in_req_valid = 1'b0;
        #1 chk("max_p4_again", pending_count, 4); chk("max_tag14", out_req_tag, 14);
        chk("max_valid14", out_req_valid, 1);
        tick();
        out_rsp_valid = 1'b1; repeat (4) tick(); out_rsp_valid = 1'b0;
        #1 chk("max_drain_p0", pending_count, 0);

        // downstream stall: 2 buffered, stable, order kept
        out_req_ready = 1'b0;
        offer(1'b0, 8'd20);
        #1 chk("st_ready_a", in_req_ready, 1);
        tick(); offer(1'b0, 8'd21);
        #1 chk("st_ready_b", in_req_ready, 1); chk("st_head_a", out_req_tag, 20);
        tick(); offer(1'b0, 8'd22);
        #1 chk("st_full", in_req_ready, 0); chk("st_head_b", out_req_tag, 20);
        chk("st_addr_b", out_req_addr, 32'h114);
        tick();
        #1 chk("st_head_c", out_req_tag, 20); chk("st_data_c", out_req_data, 32'hA5000014);
        tick(); out_req_ready = 1'b1;
        #1 chk("st_release_ready", in_req_ready, 0);
        tick();
        #1 chk("st_tag21", out_req_tag, 21); chk("st_ready_again", in_req_ready, 1);
        tick(); in_req_valid = 1'b0;
        #1 chk("st_tag22", out_req_tag, 22); chk("st_p3", pending_count, 3);
        tick();
        #1 chk("st_empty", out_req_valid, 0);

        // coincident read/response and writes
        out_rsp_valid = 1'b1; tick();
        #1 chk("co_p2", pending_count, 2);
        offer(1'b0, 8'd30); tick();
        offer(1'b1, 8'd31); out_rsp_valid = 1'b0;
        #1 chk("co_both_p2", pending_count, 2);
        tick(); offer(1'b1, 8'd32); tick(); in_req_valid = 1'b0;
        #1 chk("wr_p2", pending_count, 2); chk("wr_tag32", out_req_tag, 32);
        chk("wr_rw", out_req_rw, 1);
        out_rsp_valid = 1'b1; repeat (2) tick(); out_rsp_valid = 1'b0;
        #1 chk("co_p0", pending_count, 0); chk("co_idle", idle, 1);

        // underflow handling
        offer(1'b0, 8'd40); out_rsp_valid = 1'b1; tick();
        in_req_valid = 1'b0; out_rsp_valid = 1'b0;
        #1 chk("uf_co_p0", pending_count, 0); chk("uf_co_err", underflow_err, 0);
        tick();
        out_rsp_valid = 1'b1; tick(); out_rsp_valid = 1'b0;
        #1 chk("uf_err", underflow_err, 1); chk("uf_p0", pending_count, 0);
        tick();
        #1 chk("uf_sticky", underflow_err, 1);

        // drain with buffered reads
        reset = 1'b0; tick(); reset = 1'b1;
        #1 chk("dr_err_clr", underflow_err, 0); chk("dr_idle0", idle, 1);
        out_req_ready = 1'b0;
        offer(1'b0, 8'd50); tick();
        offer(1'b0, 8'd51); tick();
        offer(1'b0, 8'd52); drain = 1'b1; out_req_ready = 1'b1;
        #1 chk("dr_ready", in_req_ready, 0); chk("dr_p2", pending_count, 2);
        chk("dr_head", out_req_tag, 50);
        tick();
        #1 chk("dr_tag51", out_req_tag, 51);
        tick();
        #1 chk("dr_empty", out_req_valid, 0); chk("dr_idle_busy", idle, 0);
        out_rsp_valid = 1'b1; tick();
        #1 chk("dr_idle_mid", idle, 0);
        tick(); out_rsp_valid = 1'b0;
        #1 chk("dr_idle_rise", idle, 1); chk("dr_ready_hold", in_req_ready, 0);
        tick();
        #1 chk("dr_no_accept", pending_count, 0);

        // reset mid-stream discards buffered reads
        drain = 1'b0; out_req_ready = 1'b0;
        offer(1'b0, 8'd60); tick();
        offer(1'b0, 8'd61); tick();
        #1 chk("mr_valid", out_req_valid, 1); chk("mr_p2", pending_count, 2);
        reset = 1'b0;
        #1 chk("mr_ready_rst", in_req_ready, 0);
        tick(); in_req_valid = 1'b0;
        #1 chk("mr_idle", idle, 1); chk("mr_p0", pending_count, 0);
        chk("mr_out_valid", out_req_valid, 0);
        reset = 1'b1; out_rsp_valid = 1'b1; tick(); out_rsp_valid = 1'b0;
        #1 chk("mr_late_rsp_err", underflow_err, 1); chk("mr_late_p0", pending_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_pending_tracker.md
MEM_PENDING_TRACKER -- requirements
Module: VX_mem_pending_tracker

Interface
REQ-001 SHALL be a single-channel stage between one VX_lsu_adapter output channel and the memory side (dcache or local memory), one instance per channel.
REQ-002 SHALL have parameter WORD_SIZE, default 4, data word size in bytes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 30, word address width.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, request/response tag width.
REQ-005 SHALL have parameter MAX_PENDING, default 16, maximum outstanding reads (legal range 1..255); CNT_W = CLOG2(MAX_PENDING+1).
REQ-006 clk  in  1  single clock, all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset: reset=0 at a rising clk edge resets the block.
REQ-008 in_req_valid/in_req_ready  in/out  1/1  upstream request handshake.
REQ-009 in_req_rw  in  1  1=write, 0=read.
REQ-010 in_req_byteen  in  WORD_SIZE;  in_req_addr  in  ADDR_WIDTH;  in_req_data  in  WORD_SIZE*8;  in_req_tag  in  TAG_WIDTH.
REQ-011 out_req_valid/rw/byteen/addr/data/tag  out  same widths  downstream request; out_req_ready  in  1.
REQ-012 out_rsp_valid  in  1;  out_rsp_data  in  WORD_SIZE*8;  out_rsp_tag  in  TAG_WIDTH;  out_rsp_ready  out  1 -- memory-side response.
REQ-013 in_rsp_valid  out  1;  in_rsp_data  out  WORD_SIZE*8;  in_rsp_tag  out  TAG_WIDTH;  in_rsp_ready  in  1 -- upstream response.
REQ-014 drain  in  1  when 1, blocks new request acceptance.
REQ-015 idle  out  1  no outstanding reads and request buffer empty.
REQ-016 pending_count  out  CNT_W  current outstanding read count.
REQ-017 underflow_err  out  1  sticky: response seen with zero outstanding reads.

Function
REQ-018 Request path SHALL be a 2-entry elastic buffer, FIFO order; a request accepted in cycle N is first presented on out_req_* in cycle N+1.
REQ-019 Sustained throughput SHALL be 1 request/cycle while out_req_ready=1; out_req_* SHALL be held stable while out_req_valid=1 and out_req_ready=0.
REQ-020 in_req_ready SHALL be 1 iff buffer has a free entry AND pending_count < MAX_PENDING AND drain=0; it SHALL NOT depend on in_req_rw.
REQ-021 Request fire = in_req_valid & in_req_ready; read fire = fire & (in_req_rw=0); writes produce no response and are not counted.
REQ-022 Response path SHALL be combinational pass-through: in_rsp_valid=out_rsp_valid, in_rsp_data/tag = out_rsp_data/tag, out_rsp_ready=in_rsp_ready.
REQ-023 Response fire = out_rsp_valid & in_rsp_ready.
REQ-024 pending_count SHALL update each cycle: +1 on read fire only, -1 on response fire only, unchanged when both or neither occur.
REQ-025 Response fire with pending_count=0 and no read fire in the same cycle: count SHALL stay 0 (no wrap), underflow_err SHALL set to 1 and stay 1 until reset.
REQ-026 Response fire with pending_count=0 coincident with read fire: count SHALL stay 0, underflow_err SHALL NOT set.
REQ-027 pending_count SHALL never exceed MAX_PENDING; at MAX_PENDING, in_req_ready=0 until a response fire, and the ready rise SHALL occur in the cycle after that response fire.
REQ-028 drain=1 SHALL NOT stall buffered requests or responses; buffered entries continue to issue.
REQ-029 idle SHALL be combinational: 1 iff pending_count=0 AND buffer empty.

Reset
REQ-030 On reset=0: buffer emptied, out_req_valid=0, pending_count=0, underflow_err=0, idle=1; in_req_ready=0 during reset cycles.
REQ-031 Reset mid-operation SHALL discard buffered requests and clear the count; responses arriving after reset for discarded reads SHALL raise underflow_err.
REQ-032 First acceptance SHALL be possible in the first cycle with reset=1.

Verification
REQ-033 Back-to-back 4 reads, tags 0..3, out_req_ready=1 -> out_req tags 0..3 on cycles N+1..N+4, pending_count reaches 4, idle=0.
REQ-034 MAX_PENDING=4, 6 reads offered, no responses -> exactly 4 accepted, in_req_ready=0, pending_count=4; one response fire -> ready=1 next cycle, 5th accepted.
REQ-035 out_req_ready=0 for 3 cycles with 3 requests offered -> 2 buffered, in_req_ready=0, out_req_* stable; ready=1 -> order preserved, no loss or duplication.
REQ-036 pending_count=2, read fire and response fire same cycle -> pending_count stays 2; 2 writes -> count unchanged.
REQ-037 pending_count=0, lone response fire -> underflow_err=1, count=0; coincident read+response at 0 -> err not set.
REQ-038 drain=1 with 2 buffered reads, then 2 responses returned -> no new acceptance, idle rises after last response fire; reset=0 mid-stream -> idle=1, count=0, out_req_valid=0 next cycle.
